// File: rtl/pipe_wallace_mul.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier, unsigned or Baugh-Wooley signed per transaction.
// Ranks: operand capture, partial-product rows, carry-save pair, final sum; the whole pipe freezes on stall.
module pipe_wallace_mul #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 out_signed,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned ROWS = WIDTH + 1;
    localparam int unsigned XW   = $clog2(WIDTH);
    localparam int unsigned RW   = $clog2(ROWS);
    localparam logic [WIDTH-1:0] MSB_MASK  = WIDTH'(1) << (WIDTH - 1);
    localparam logic [PW-1:0]    CONST_ROW = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    logic adv;
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    logic               v0, sg0;
    logic [WIDTH-1:0]   x0, y0;
    logic [TAG_W-1:0]   tag0;
    logic               v1, sg1;
    logic [TAG_W-1:0]   tag1;
    logic [PW-1:0]      pp_q [ROWS];
    logic               v2, sg2;
    logic [TAG_W-1:0]   tag2;
    logic [PW-1:0]      sum_q, carry_q;

    logic [PW-1:0]      pp [ROWS];
    logic [PW-1:0]      rows [ROWS];
    logic [PW-1:0]      nxt [ROWS];
    logic [PW-1:0]      fa_a, fa_b, fa_c;
    logic [PW-1:0]      red_sum, red_carry;
    logic [WIDTH-1:0]   ab;
    int                 n, g, rem;

    // AND array; in signed mode the terms with exactly one sign bit are inverted
    always_comb begin
        ab = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            ab = x0 & {WIDTH{y0[XW'(j)]}};
            if (sg0) begin
                ab = (j == int'(WIDTH) - 1) ? (ab ^ ~MSB_MASK) : (ab ^ MSB_MASK);
            end
            pp[RW'(j)] = PW'(ab) << j;
        end
        pp[RW'(WIDTH)] = sg0 ? CONST_ROW : '0;
    end

    // Wallace reduction: each layer feeds row triples through full adders until two rows remain
    always_comb begin
        rows  = pp_q;
        nxt   = pp_q;
        fa_a  = '0;
        fa_b  = '0;
        fa_c  = '0;
        n     = int'(ROWS);
        g     = 0;
        rem   = 0;
        for (int l = 0; l < int'(ROWS); l++) begin
            if (n > 2) begin
                g   = n / 3;
                rem = n - 3 * g;
                for (int r = 0; r < int'(ROWS); r++) nxt[RW'(r)] = '0;
                for (int i = 0; i < int'(ROWS / 3); i++) begin
                    if (i < g) begin
                        fa_a = rows[RW'(3 * i)];
                        fa_b = rows[RW'(3 * i + 1)];
                        fa_c = rows[RW'(3 * i + 2)];
                        nxt[RW'(2 * i)]     = fa_a ^ fa_b ^ fa_c;
                        nxt[RW'(2 * i + 1)] = ((fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c)) << 1;
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    if (r < rem) nxt[RW'(2 * g + r)] = rows[RW'(3 * g + r)];
                end
                rows = nxt;
                n    = 2 * g + rem;
            end
        end
        red_sum   = rows[0];
        red_carry = rows[1];
    end

    // Pipeline ranks; data only loads behind a valid slot so bubbles cost no toggling
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0          <= 1'b0;
            sg0         <= 1'b0;
            x0          <= '0;
            y0          <= '0;
            tag0        <= '0;
            v1          <= 1'b0;
            sg1         <= 1'b0;
            tag1        <= '0;
            pp_q        <= '{default: '0};
            v2          <= 1'b0;
            sg2         <= 1'b0;
            tag2        <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            out_valid   <= 1'b0;
            out_signed  <= 1'b0;
            out_tag     <= '0;
            out_product <= '0;
        end else if (adv) begin
            v0        <= in_valid;
            v1        <= v0;
            v2        <= v1;
            out_valid <= v2;
            if (in_valid) begin
                sg0  <= in_signed;
                x0   <= in_x;
                y0   <= in_y;
                tag0 <= in_tag;
            end
            if (v0) begin
                sg1  <= sg0;
                tag1 <= tag0;
                pp_q <= pp;
            end
            if (v1) begin
                sg2     <= sg1;
                tag2    <= tag1;
                sum_q   <= red_sum;
                carry_q <= red_carry;
            end
            if (v2) begin
                out_signed  <= sg2;
                out_tag     <= tag2;
                out_product <= sum_q + carry_q;
            end
        end
    end
endmodule

// File: tb/tb_pipe_wallace_mul.sv
// Randomised and directed bench for pipe_wallace_mul (WIDTH=16, TAG_W=8) against an arithmetic reference.
module tb_pipe_wallace_mul;
    localparam int W   = 16;
    localparam int TW  = 8;
    localparam int PW  = 2 * W;
    localparam int LAT = 4;   // result visible in the cycle after edge k+3

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_signed;
    logic [W-1:0]      in_x, in_y;
    logic [TW-1:0]     in_tag;
    logic              out_valid, out_ready, out_signed;
    logic [PW-1:0]     out_product;
    logic [TW-1:0]     out_tag;

    pipe_wallace_mul #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .out_signed(out_signed), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] prod;
        logic [TW-1:0] tag;
        logic          sg;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   lat_chk = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint px, py;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        return PW'(px * py);
    endfunction

    function automatic logic [W-1:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return W'(16'h8000);
            4:       return W'(16'h7FFF);
            default: return W'($urandom);
        endcase
    endfunction

    // One clock: drive at negedge, then score what the next rising edge will transfer
    task automatic step(input logic iv, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [TW-1:0] t, input logic ordy, output logic took);
        @(negedge clk);
        in_valid = iv; in_signed = s; in_x = x; in_y = y; in_tag = t; out_ready = ordy;
        #1;
        cyc++;
        check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 64'(out_valid), 64'(0));
            end else begin
                check("product", 64'(out_product), 64'(q[0].prod));
                check("tag", 64'(out_tag), 64'(q[0].tag));
                check("signed", 64'(out_signed), 64'(q[0].sg));
                if (out_ready) begin
                    if (lat_chk) check("latency", 64'(cyc - q[0].cyc), 64'(LAT));
                    void'(q.pop_front());
                end
            end
        end
        took = iv && in_ready;
        if (took) q.push_back('{ref_mul(s, x, y), t, s, cyc});
    endtask

    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic [TW-1:0] t);
        logic took;
        took = 1'b0;
        for (int i = 0; i < 50 && !took; i++) step(1'b1, s, x, y, t, 1'b1, took);
        if (!took) check("issue_timeout", 64'(took), 64'(1));
    endtask

    task automatic drain(input int budget);
        logic took;
        for (int i = 0; i < budget && q.size() > 0; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, took);
        check("drain_left", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic took;
        logic have;
        logic hs;
        logic [W-1:0] hx, hy;
        logic [TW-1:0] ht;
        int accepted;
        int guard;

        rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_product", 64'(out_product), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_out_signed", 64'(out_signed), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // back-to-back unsigned, latency and full throughput
        lat_chk = 1'b1;
        issue(1'b0, 16'hFFFF, 16'hFFFF, 8'hA1);
        issue(1'b0, 16'h0000, 16'd173,  8'hA2);
        issue(1'b0, 16'h0001, 16'd200,  8'hA3);
        check("max_unsigned_ref", 64'(ref_mul(1'b0, 16'hFFFF, 16'hFFFF)), 64'h0000_0000_FFFE_0001);
        // signed corner cases, mode toggling between neighbours
        issue(1'b1, 16'h8000, 16'h8000, 8'hB1);
        issue(1'b1, 16'hFFFF, 16'h0001, 8'hB2);
        issue(1'b1, 16'h8000, 16'h7FFF, 8'hB3);
        issue(1'b0, 16'h8000, 16'h8000, 8'hB4);
        drain(20);

        // bubbles: one-cycle gaps must survive the pipe
        for (int i = 0; i < 10; i++)
            step(i % 2 == 0, 1'(i % 4 == 0), W'($urandom), W'($urandom), TW'(8'hC0 + i), 1'b1, took);
        drain(20);

        // backpressure: stall the head for 5 cycles while a new op waits upstream
        lat_chk = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'(i % 2), W'($urandom), W'($urandom), TW'(8'hD0 + i));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'h1234, 16'hFEDC, 8'hD4, 1'b0, took);
        issue(1'b1, 16'h1234, 16'hFEDC, 8'hD4);
        drain(30);

        // reset with three operations in flight
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) issue(1'b0, 16'h00FF, W'(i + 2), TW'(8'hE0 + i));
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_product", 64'(out_product), 64'(0));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, took);

        // random mixed traffic with random backpressure
        lat_chk = 1'b0;
        have = 1'b0; hs = 1'b0; hx = '0; hy = '0; ht = '0;
        accepted = 0; guard = 0;
        while (accepted < 10000 && guard < 40000) begin
            guard++;
            if (!have && $urandom_range(0, 3) != 0) begin
                have = 1'b1;
                hs = 1'($urandom_range(0, 1));
                hx = pick_op();
                hy = pick_op();
                ht = TW'($urandom);
            end
            step(have, hs, hx, hy, ht, 1'($urandom_range(0, 3) != 0), took);
            if (took) begin
                have = 1'b0;
                accepted++;
            end
        end
        check("random_accepted", 64'(accepted), 64'(10000));
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_wallace_mul.md
Name: pipe_wallace_mul

Overview:
- Parametrised, pipelined successor to the team's 8x8 combinational Wallace-tree multiplier.
- Multiplies two WIDTH-bit operands, unsigned or two's-complement, selected per transaction.
- Fixed 3-stage pipeline with valid/ready handshake on input and output. Full-throughput: one product per clock when not stalled.
- Sits between the BCD digit accumulator and the binary result register in the Bcd2Binary datapath; carries an opaque tag alongside each operation.

Parameters:
- WIDTH, 8, operand width in bits (legal 4..32); product is 2*WIDTH bits.
- TAG_W, 4, width of the sideband tag carried unchanged with each operation (legal 1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and tag valid this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- in_signed  input  1  1 = operands are two's complement; 0 = unsigned.
- in_x  input  WIDTH  multiplicand.
- in_y  input  WIDTH  multiplier.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts the product this cycle.
- out_product  output  2*WIDTH  x*y; two's complement when signed.
- out_signed  output  1  in_signed of this result.
- out_tag  output  TAG_W  in_tag of this result.

Behaviour:
- Reset: synchronous on clk while rst_n=0.
  - All stage valid bits clear; out_valid=0; out_product=0; out_tag=0; out_signed=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight transaction; nothing is emitted afterwards.
- Transfer rules: input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1): register the operands, mode and tag. Generate the WIDTH x WIDTH partial-product AND array.
  - Signed mode: Baugh-Wooley form. Invert the partial products involving exactly one sign bit. Add constant 1 at column WIDTH and at column 2*WIDTH-1.
- Stage 2 (S2): Wallace reduction with HA/FA cells to two 2*WIDTH vectors (sum, carry). Register both vectors with the mode and tag.
- Stage 3 (S3): a final 2*WIDTH-bit carry-propagate add into out_product. Discard the carry out of bit 2*WIDTH-1.
- Latency: a transfer at edge k presents its result with out_valid=1 after edge k+3, absent stalls. Results emerge strictly in acceptance order.
- Stall: stall = out_valid && !out_ready.
  - While stalled, every stage register (data and valid) holds its value.
  - in_ready = !stall, which is combinational from out_ready.
  - out_product, out_tag and out_signed stay stable while out_valid=1 and out_ready=0.
- Bubbles: cycles with in_valid=0 insert invalid slots. Bubbles advance when not stalled; they are not compressed.
- Throughput: with out_ready held at 1 and in_valid held at 1, one transfer and one result occur every cycle.
- Arithmetic checks:
  - Unsigned result = x*y exactly, in 2*WIDTH bits; no overflow is possible.
  - Signed results span -(2^(2W-2)-2^(W-1)) .. 2^(2W-2), exact in 2*WIDTH bits.
  - Edge case MIN*MIN = +2^(2W-2) must be exact.
- Simultaneous events:
  - Input and output transfers in the same cycle are legal; the pipeline advances.
  - in_valid while stalled is not accepted, because in_ready=0. The source must hold its data.
- Zero operands, and a mode change between consecutive transactions, need no special handling.

Test Plan:
- WIDTH=8, unsigned, out_ready=1. 255*255, then 0*173, then 1*200, in consecutive cycles. Results 0xFE01, 0x0000, 0x00C8 with out_valid on 3 consecutive cycles, first at edge 3, tags preserved.
- WIDTH=8, signed: -128*-128 -> 0x4000; -1*1 -> 0xFFFF; -128*127 -> 0xC080; 0x80*0x80 in unsigned mode -> 0x4000, with out_signed matching each transaction.
- Backpressure: issue 4 ops back-to-back, drop out_ready for 5 cycles after the first result. The first result holds stable, in_ready=0 during the stall, and all 4 results are delivered in order with none lost or duplicated.
- Bubbles: alternate in_valid 1/0 with out_ready=1. Results appear spaced by one-cycle gaps, latency exactly 3.
- Reset mid-flight: accept 3 ops, assert rst_n=0 for 1 cycle. out_valid=0 and out_product=0 next cycle; no stale results appear afterwards.
- WIDTH=16, TAG_W=8, random 10k ops, signed and unsigned mixed, random out_ready. Every product matches the reference model; 0xFFFF*0xFFFF unsigned -> 0xFFFE0001.
